// File: rtl/pia_pkg.sv
// Shared definitions for the MC6821-compatible PIA: register map,
// control-register bit positions and the C2 line operating modes.
package pia_pkg;

  localparam logic [1:0] PIA_DATA_A = 2'd0;
  localparam logic [1:0] PIA_CR_A   = 2'd1;
  localparam logic [1:0] PIA_DATA_B = 2'd2;
  localparam logic [1:0] PIA_CR_B   = 2'd3;

  localparam int CR_C1_IRQEN  = 0;
  localparam int CR_C1_EDGE   = 1;
  localparam int CR_DDR_SEL   = 2;
  localparam int CR_C2_CTL_LO = 3;
  localparam int CR_C2_EDGE   = 4;
  localparam int CR_C2_CTL_HI = 5;
  localparam int CR_IRQ2      = 6;
  localparam int CR_IRQ1      = 7;

  typedef enum logic [1:0] {
    C2_IN,
    C2_HANDSHAKE,
    C2_PULSE,
    C2_MANUAL
  } c2_mode_e;

  // Decode CR[5:3] into the C2 line mode.
  function automatic c2_mode_e c2_mode(input logic [2:0] ctl);
    if (!ctl[2]) return C2_IN;
    if (ctl[1])  return C2_MANUAL;
    if (ctl[0])  return C2_PULSE;
    return C2_HANDSHAKE;
  endfunction

endpackage

// File: rtl/pia_side.sv
// One side (A or B) of the PIA: DDR/OR/CR registers, control-line
// synchronisers with edge detection, IRQ flags and the C2 output sequencer.
//
// state          | meaning
// ---------------+------------------------------------------------------
// C2S_HIGH       | C2 idle high (input mode, or output mode awaiting trigger)
// C2S_HS_LOW     | handshake: C2 held low until the next active C1 edge
// C2S_PULSE_LOW  | pulse: C2 low for the current clk_ena cycle only
// C2S_MANUAL     | manual: C2 follows CR[3]
module pia_side
  import pia_pkg::*;
#(
  parameter int PORT_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit IS_B        = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              wr_cr_i,
  input  logic              wr_ddr_i,
  input  logic              wr_or_i,
  input  logic              rd_data_i,
  input  logic [5:0]        cr_wdata_i,
  input  logic [PORT_W-1:0] port_wdata_i,
  input  logic [PORT_W-1:0] pins_i,
  input  logic              c1_i,
  input  logic              c2_i,
  output logic [7:0]        cr_o,
  output logic [PORT_W-1:0] ddr_o,
  output logic [PORT_W-1:0] or_o,
  output logic [PORT_W-1:0] data_o,
  output logic              irq_o,
  output logic              c2_o,
  output logic              c2_oe_o
);

  typedef enum logic [1:0] {
    C2S_HIGH,
    C2S_HS_LOW,
    C2S_PULSE_LOW,
    C2S_MANUAL
  } c2_state_e;

  logic [5:0]             cr_q, cr_d;
  logic [PORT_W-1:0]      ddr_q, or_q;
  logic [SYNC_STAGES-1:0] c1_sync_q, c2_sync_q;
  logic                   c1_prev_q, c2_prev_q;
  logic                   irq1_q, irq1_d, irq2_q, irq2_d;
  logic                   c1_s, c2_s, c1_edge, c2_edge, trig;
  c2_state_e              state_q;
  logic                   c2_q;
  c2_mode_e               mode_new, mode_old;

  assign cr_d = wr_cr_i ? cr_wdata_i : cr_q;
  assign c1_s = c1_sync_q[SYNC_STAGES-1];
  assign c2_s = c2_sync_q[SYNC_STAGES-1];

  assign c1_edge = clk_ena & (cr_q[CR_C1_EDGE] ? (c1_s & ~c1_prev_q) : (~c1_s & c1_prev_q));
  assign c2_edge = clk_ena & ~cr_q[CR_C2_CTL_HI] &
                   (cr_q[CR_C2_EDGE] ? (c2_s & ~c2_prev_q) : (~c2_s & c2_prev_q));

  // Side A handshakes on CPU reads of port data, side B on CPU writes.
  assign trig = IS_B ? wr_or_i : rd_data_i;

  // A new edge in the same cycle as the clearing read keeps the flag set.
  assign irq1_d = c1_edge | (irq1_q & ~rd_data_i);
  assign irq2_d = ~cr_d[CR_C2_CTL_HI] & (c2_edge | (irq2_q & ~rd_data_i));

  assign mode_new = c2_mode(cr_d[CR_C2_CTL_HI:CR_C2_CTL_LO]);
  assign mode_old = c2_mode(cr_q[CR_C2_CTL_HI:CR_C2_CTL_LO]);

  // Registers, synchronisers, previous samples and flags advance on clk_ena.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cr_q      <= '0;
      ddr_q     <= '0;
      or_q      <= '0;
      c1_sync_q <= '0;
      c2_sync_q <= '0;
      c1_prev_q <= 1'b0;
      c2_prev_q <= 1'b0;
      irq1_q    <= 1'b0;
      irq2_q    <= 1'b0;
    end else if (clk_ena) begin
      cr_q <= cr_d;
      if (wr_ddr_i) ddr_q <= port_wdata_i;
      if (wr_or_i)  or_q  <= port_wdata_i;
      c1_sync_q[0] <= c1_i;
      c2_sync_q[0] <= c2_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        c1_sync_q[i] <= c1_sync_q[i-1];
        c2_sync_q[i] <= c2_sync_q[i-1];
      end
      c1_prev_q <= c1_s;
      c2_prev_q <= c2_s;
      irq1_q    <= irq1_d;
      irq2_q    <= irq2_d;
    end
  end

  // C2 output sequencer; a trigger outranks a coincident C1 release edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= C2S_HIGH;
      c2_q    <= 1'b1;
    end else if (clk_ena) begin
      if (mode_new == C2_IN) begin
        state_q <= C2S_HIGH;
        c2_q    <= 1'b1;
      end else if (mode_new == C2_MANUAL) begin
        state_q <= C2S_MANUAL;
        c2_q    <= cr_d[CR_C2_CTL_LO];
      end else if (wr_cr_i && (mode_new != mode_old)) begin
        state_q <= C2S_HIGH;
        c2_q    <= 1'b1;
      end else if (trig) begin
        state_q <= (mode_new == C2_PULSE) ? C2S_PULSE_LOW : C2S_HS_LOW;
        c2_q    <= 1'b0;
      end else if ((state_q == C2S_PULSE_LOW) || ((state_q == C2S_HS_LOW) && c1_edge)) begin
        state_q <= C2S_HIGH;
        c2_q    <= 1'b1;
      end
    end
  end

  // Read-back view of the control register with the live flags on top.
  always_comb begin
    cr_o          = {2'b00, cr_q};
    cr_o[CR_IRQ1] = irq1_q;
    cr_o[CR_IRQ2] = irq2_q;
  end

  assign irq_o   = (irq1_q & cr_q[CR_C1_IRQEN]) |
                   (irq2_q & cr_q[CR_C2_CTL_LO] & ~cr_q[CR_C2_CTL_HI]);
  assign ddr_o   = ddr_q;
  assign or_o    = or_q;
  assign data_o  = IS_B ? ((or_q & ddr_q) | (pins_i & ~ddr_q)) : pins_i;
  assign c2_o    = c2_q;
  assign c2_oe_o = cr_q[CR_C2_CTL_HI];

endmodule

// File: rtl/pia_mc6821x.sv
// MC6821-compatible PIA top level: CPU access decode, two port sides and
// the read-data multiplexer.
module pia_mc6821x
  import pia_pkg::*;
#(
  parameter int PORT_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              cs,
  input  logic              rw,
  input  logic [1:0]        addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              irqa,
  output logic              irqb,
  input  logic [PORT_W-1:0] pa_i,
  output logic [PORT_W-1:0] pa_o,
  output logic [PORT_W-1:0] pa_oe,
  input  logic              ca1,
  input  logic              ca2_i,
  output logic              ca2_o,
  output logic              ca2_oe,
  input  logic [PORT_W-1:0] pb_i,
  output logic [PORT_W-1:0] pb_o,
  output logic [PORT_W-1:0] pb_oe,
  input  logic              cb1,
  input  logic              cb2_i,
  output logic              cb2_o,
  output logic              cb2_oe
);

  logic              acc_rd, acc_wr;
  logic [7:0]        cra, crb;
  logic [PORT_W-1:0] data_a, data_b;
  logic              wr_cr_a, wr_ddr_a, wr_or_a, rd_data_a;
  logic              wr_cr_b, wr_ddr_b, wr_or_b, rd_data_b;

  assign acc_rd = clk_ena & cs & rw;
  assign acc_wr = clk_ena & cs & ~rw;

  assign wr_cr_a   = acc_wr & (addr == PIA_CR_A);
  assign wr_ddr_a  = acc_wr & (addr == PIA_DATA_A) & ~cra[CR_DDR_SEL];
  assign wr_or_a   = acc_wr & (addr == PIA_DATA_A) &  cra[CR_DDR_SEL];
  assign rd_data_a = acc_rd & (addr == PIA_DATA_A) &  cra[CR_DDR_SEL];

  assign wr_cr_b   = acc_wr & (addr == PIA_CR_B);
  assign wr_ddr_b  = acc_wr & (addr == PIA_DATA_B) & ~crb[CR_DDR_SEL];
  assign wr_or_b   = acc_wr & (addr == PIA_DATA_B) &  crb[CR_DDR_SEL];
  assign rd_data_b = acc_rd & (addr == PIA_DATA_B) &  crb[CR_DDR_SEL];

  pia_side #(
    .PORT_W     (PORT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .IS_B       (1'b0)
  ) u_side_a (
    .clk         (clk),
    .reset       (reset),
    .clk_ena     (clk_ena),
    .wr_cr_i     (wr_cr_a),
    .wr_ddr_i    (wr_ddr_a),
    .wr_or_i     (wr_or_a),
    .rd_data_i   (rd_data_a),
    .cr_wdata_i  (data_in[5:0]),
    .port_wdata_i(data_in[PORT_W-1:0]),
    .pins_i      (pa_i),
    .c1_i        (ca1),
    .c2_i        (ca2_i),
    .cr_o        (cra),
    .ddr_o       (pa_oe),
    .or_o        (pa_o),
    .data_o      (data_a),
    .irq_o       (irqa),
    .c2_o        (ca2_o),
    .c2_oe_o     (ca2_oe)
  );

  pia_side #(
    .PORT_W     (PORT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .IS_B       (1'b1)
  ) u_side_b (
    .clk         (clk),
    .reset       (reset),
    .clk_ena     (clk_ena),
    .wr_cr_i     (wr_cr_b),
    .wr_ddr_i    (wr_ddr_b),
    .wr_or_i     (wr_or_b),
    .rd_data_i   (rd_data_b),
    .cr_wdata_i  (data_in[5:0]),
    .port_wdata_i(data_in[PORT_W-1:0]),
    .pins_i      (pb_i),
    .c1_i        (cb1),
    .c2_i        (cb2_i),
    .cr_o        (crb),
    .ddr_o       (pb_oe),
    .or_o        (pb_o),
    .data_o      (data_b),
    .irq_o       (irqb),
    .c2_o        (cb2_o),
    .c2_oe_o     (cb2_oe)
  );

  // Read mux; narrow ports leave the upper data bits at zero.
  always_comb begin
    data_out = 8'h00;
    case (addr)
      PIA_DATA_A: data_out[PORT_W-1:0] = cra[CR_DDR_SEL] ? data_a : pa_oe;
      PIA_CR_A:   data_out = cra;
      PIA_DATA_B: data_out[PORT_W-1:0] = crb[CR_DDR_SEL] ? data_b : pb_oe;
      default:    data_out = crb;
    endcase
  end

endmodule

// File: tb/tb_pia_mc6821x.sv
// Bench for pia_mc6821x: directed checks of the main PIA behaviours followed
// by randomized bus/pin traffic compared with a behavioural model.
module tb_pia_mc6821x;

  localparam int PW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0, reset = 1'b0, clk_ena = 1'b0, cs = 1'b0, rw = 1'b1;
  logic [1:0]    addr = 2'd0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic          irqa, irqb;
  logic [PW-1:0] pa_i = '0, pa_o, pa_oe, pb_i = '0, pb_o, pb_oe;
  logic          ca1 = 1'b0, ca2_i = 1'b0, ca2_o, ca2_oe;
  logic          cb1 = 1'b0, cb2_i = 1'b0, cb2_o, cb2_oe;
  logic [7:0]    rd_val;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pia_mc6821x #(.PORT_W(PW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .irqa(irqa), .irqb(irqb),
    .pa_i(pa_i), .pa_o(pa_o), .pa_oe(pa_oe), .ca1(ca1), .ca2_i(ca2_i),
    .ca2_o(ca2_o), .ca2_oe(ca2_oe), .pb_i(pb_i), .pb_o(pb_o), .pb_oe(pb_oe),
    .cb1(cb1), .cb2_i(cb2_i), .cb2_o(cb2_o), .cb2_oe(cb2_oe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0] m_or[2], m_ddr[2];
  logic [5:0]    m_cr[2];
  logic          m_f1[2], m_f2[2], m_c2[2];
  int            m_rel[2];   // how a low C2 returns high: 0 never, 1 next cycle, 2 on C1 edge
  logic          hq[4][$];   // per control line: inputs seen at the last SS+1 enabled edges

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      m_or[s] = '0; m_ddr[s] = '0; m_cr[s] = '0;
      m_f1[s] = 1'b0; m_f2[s] = 1'b0; m_c2[s] = 1'b1; m_rel[s] = 0;
    end
    for (int l = 0; l < 4; l++) begin
      hq[l].delete();
      for (int k = 0; k <= SS; k++) hq[l].push_back(1'b0);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    logic [7:0] v;
    v = '0;
    case (a)
      2'd0:    v[PW-1:0] = m_cr[0][2] ? pa_i : m_ddr[0];
      2'd1:    v = {m_f1[0], m_f2[0], m_cr[0]};
      2'd2:    v[PW-1:0] = m_cr[1][2] ? ((m_or[1] & m_ddr[1]) | (pb_i & ~m_ddr[1])) : m_ddr[1];
      default: v = {m_f1[1], m_f2[1], m_cr[1]};
    endcase
    return v;
  endfunction

  function automatic logic m_irq(input int s);
    return (m_f1[s] && m_cr[s][0]) || (m_f2[s] && m_cr[s][3] && !m_cr[s][5]);
  endfunction

  // Advance the model by one enabled clock edge.
  task automatic m_step(input logic c, input logic r, input logic [1:0] a, input logic [7:0] wd);
    logic [3:0] pin;
    pin = {cb2_i, cb1, ca2_i, ca1};
    for (int s = 0; s < 2; s++) begin
      logic n1, o1, n2, o2, e1, e2, hit, rdd, wrd, trig, crw;
      logic [5:0] nc;
      n1 = hq[2*s][1];   o1 = hq[2*s][0];
      n2 = hq[2*s+1][1]; o2 = hq[2*s+1][0];
      e1 = m_cr[s][1] ? (n1 && !o1) : (!n1 && o1);
      e2 = !m_cr[s][5] && (m_cr[s][4] ? (n2 && !o2) : (!n2 && o2));
      hit  = c && (a[1] == 1'(s));
      rdd  = hit && r && !a[0] && m_cr[s][2];
      wrd  = hit && !r && !a[0] && m_cr[s][2];
      trig = (s == 0) ? rdd : wrd;
      crw  = hit && !r && a[0];
      nc   = crw ? wd[5:0] : m_cr[s];
      if (hit && !r && !a[0]) begin
        if (m_cr[s][2]) m_or[s] = wd[PW-1:0];
        else            m_ddr[s] = wd[PW-1:0];
      end
      if (e1) m_f1[s] = 1'b1; else if (rdd) m_f1[s] = 1'b0;
      if (e2) m_f2[s] = 1'b1; else if (rdd) m_f2[s] = 1'b0;
      if (nc[5]) m_f2[s] = 1'b0;
      if (!nc[5]) begin
        m_c2[s] = 1'b1; m_rel[s] = 0;
      end else if (nc[4]) begin
        m_c2[s] = nc[3]; m_rel[s] = 0;
      end else if (crw && (nc[5:3] != m_cr[s][5:3])) begin
        m_c2[s] = 1'b1; m_rel[s] = 0;
      end else if (trig) begin
        m_c2[s] = 1'b0; m_rel[s] = nc[3] ? 1 : 2;
      end else if (!m_c2[s] && (m_rel[s] == 1 || (m_rel[s] == 2 && e1))) begin
        m_c2[s] = 1'b1; m_rel[s] = 0;
      end
      m_cr[s] = nc;
    end
    for (int l = 0; l < 4; l++) begin
      void'(hq[l].pop_front());
      hq[l].push_back(pin[l]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // One bus cycle: three disabled clocks with junk accesses, then an enabled clock.
  task automatic bus(input logic c, input logic r, input logic [1:0] a, input logic [7:0] wd);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clk_ena = 1'b0; cs = 1'($urandom); rw = 1'($urandom);
      addr = 2'($urandom); data_in = 8'($urandom);
      #1 chk("rd_idle", 32'(data_out), 32'(m_read(addr)));
      @(posedge clk); #1;
      chk("c2_idle", 32'({ca2_o, cb2_o}), 32'({m_c2[0], m_c2[1]}));
    end
    @(negedge clk);
    clk_ena = 1'b1; cs = c; rw = r; addr = a; data_in = wd;
    #1 rd_val = data_out;
    chk("rd", 32'(data_out), 32'(m_read(a)));
    @(posedge clk);
    m_step(c, r, a, wd);
    #1;
    chk("ports", {pa_o, pa_oe, pb_o, pb_oe}, {m_or[0], m_ddr[0], m_or[1], m_ddr[1]});
    chk("ctl", 32'({irqa, irqb, ca2_o, cb2_o, ca2_oe, cb2_oe}),
        32'({m_irq(0), m_irq(1), m_c2[0], m_c2[1], m_cr[0][5], m_cr[1][5]}));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d); bus(1'b1, 1'b0, a, d); endtask
  task automatic rd(input logic [1:0] a); bus(1'b1, 1'b1, a, 8'h00); endtask
  task automatic idles(input int n); for (int i = 0; i < n; i++) bus(1'b0, 1'b1, 2'd0, 8'h00); endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; clk_ena = 1'b0; cs = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    chk("rst_c2", 32'({ca2_o, cb2_o}), 32'h3);
    addr = 2'd3;
    #1 chk("rst_crb", 32'(data_out), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    m_reset();
    do_reset();

    // reset state
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk("rst_read", 32'(rd_val), 32'h0);
    end
    chk("rst_outs", 32'({ca2_o, cb2_o, irqa, irqb}), 32'b1100);
    chk("rst_oe", 32'({pa_oe, pb_oe}), 32'h0);

    // port B DDR/OR and mixed read-back
    wr(2'd3, 8'h00); wr(2'd2, 8'hF0); wr(2'd3, 8'h04); wr(2'd2, 8'hA5);
    pb_i = 8'h3C;
    chk("pb_o", 32'(pb_o), 32'hA5);
    chk("pb_oe", 32'(pb_oe), 32'hF0);
    rd(2'd2);
    chk("pb_read", 32'(rd_val), 32'hAC);

    // CA1 rising edge through the synchroniser, read-to-clear
    wr(2'd1, 8'h07);
    ca1 = 1'b1;
    idles(SS);
    chk("irqa_sync_lat", 32'(irqa), 32'h0);
    idles(1);
    chk("irqa_set", 32'(irqa), 32'h1);
    rd(2'd1);
    chk("cra_flag", 32'(rd_val), 32'h87);
    rd(2'd0);
    chk("irqa_clr", 32'(irqa), 32'h0);
    rd(2'd1);
    chk("cra_clr", 32'(rd_val), 32'h07);
    ca1 = 1'b0;
    idles(4);
    rd(2'd1);
    chk("cra_fall_noflag", 32'(rd_val), 32'h07);

    // CA2 handshake
    wr(2'd1, 8'h24);
    chk("ca2_enter", 32'(ca2_o), 32'h1);
    rd(2'd0);
    chk("ca2_hs_low", 32'(ca2_o), 32'h0);
    ca1 = 1'b1; idles(4);
    chk("ca2_hs_hold", 32'(ca2_o), 32'h0);
    ca1 = 1'b0; idles(4);
    chk("ca2_hs_rel", 32'(ca2_o), 32'h1);

    // CB2 pulse and manual modes
    wr(2'd3, 8'h2C);
    wr(2'd2, 8'h55);
    chk("cb2_pulse_low", 32'(cb2_o), 32'h0);
    idles(1);
    chk("cb2_pulse_end", 32'(cb2_o), 32'h1);
    wr(2'd3, 8'h38);
    chk("cb2_man_hi", 32'(cb2_o), 32'h1);
    wr(2'd3, 8'h30);
    chk("cb2_man_lo", 32'(cb2_o), 32'h0);

    // read-clear coinciding with a new CA1 edge: set wins
    wr(2'd1, 8'h07);
    rd(2'd0);
    chk("irqa_pre", 32'(irqa), 32'h0);
    ca1 = 1'b1;
    idles(SS);
    rd(2'd0);
    chk("irqa_set_wins", 32'(irqa), 32'h1);
    rd(2'd1);
    chk("cra_set_wins", 32'(rd_val), 32'h87);

    // reset in the middle of a pulse
    wr(2'd3, 8'h2C);
    wr(2'd2, 8'h11);
    chk("cb2_pulse_pre_rst", 32'(cb2_o), 32'h0);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) ca1   = ~ca1;
      if ($urandom_range(0, 3) == 0) ca2_i = ~ca2_i;
      if ($urandom_range(0, 3) == 0) cb1   = ~cb1;
      if ($urandom_range(0, 3) == 0) cb2_i = ~cb2_i;
      pa_i = PW'($urandom);
      pb_i = PW'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else bus(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pia_mc6821x.md
Name: pia_mc6821x

Overview:
- Parametrised MC6821-compatible peripheral interface adapter that replaces the fixed 8-bit PIAs in the CoCo2 top level (keyboard/VDG-sync PIA and sound/cart PIA).
- Adds the following over the current PIA:
  - full data-direction registers;
  - per-side control registers with selectable CA1/CB1 edge;
  - CA2/CB2 input, handshake, pulse and manual-output modes;
  - read-to-clear IRQ flags;
  - input synchronisers;
  - parametrised port width.
- Bus timing is qualified by the system clock enable (clk_14M318_ena).

Parameters:
PORT_W, 8, width of PA/PB, DDR and output registers (1..8; data bus stays 8 bits, unused upper bits read 0)
SYNC_STAGES, 2, flip-flop stages on ca1/ca2_i/cb1/cb2_i before edge detection (>=1)

Ports:
clk  in  1  system clock (57.272 MHz)
reset  in  1  synchronous, active-low
clk_ena  in  1  bus/sample enable; all register updates occur only when high
cs  in  1  chip select
rw  in  1  1=read, 0=write
addr  in  2  register select
data_in  in  8  CPU write data
data_out  out  8  CPU read data (combinational from registers/pins)
irqa  out  1  side-A interrupt, active-high
irqb  out  1  side-B interrupt, active-high
pa_i  in  PORT_W  port A pins
pa_o  out  PORT_W  ORA
pa_oe  out  PORT_W  DDRA (1=output)
ca1  in  1  CA1 input
ca2_i  in  1  CA2 input
ca2_o  out  1  CA2 output
ca2_oe  out  1  high when CRA[5]=1
pb_i  in  PORT_W  port B pins
pb_o  out  PORT_W  ORB
pb_oe  out  PORT_W  DDRB
cb1  in  1  CB1 input
cb2_i  in  1  CB2 input
cb2_o  out  1  CB2 output
cb2_oe  out  1  high when CRB[5]=1

Behaviour:
- Reset (reset=0 at a clk edge): ORx, DDRx and CRx are cleared; flags are cleared; synchronisers and previous samples are cleared; ca2_o=cb2_o=1; irqa=irqb=0.
- Access: occurs on a clk cycle with clk_ena&cs. Writes take effect at that edge; data_out is valid throughout.
- Register map:
  - addr 0 -> CRA[2] ? PA data : DDRA
  - addr 1 -> CRA
  - addr 2 -> CRB[2] ? PB data : DDRB
  - addr 3 -> CRB
- Reads:
  - PA data read returns pa_i.
  - PB data read returns (ORB & DDRB) | (pb_i & ~DDRB).
- Control register bits:
  - CR[0] C1 IRQ enable.
  - CR[1] C1 active edge (1=rising).
  - CR[2] DDR/OR select.
  - CR[5:3] C2 control.
  - CR[6] IRQ2 flag, read-only.
  - CR[7] IRQ1 flag, read-only.
  - A CR write updates bits [5:0] only.
- Edge detection: the synchronised input is compared with its value at the previous clk_ena cycle. An active edge sets the flag on that clk_ena cycle.
- IRQ1 flag: set on the C1 active edge; cleared by an access-read of the side's data register (addr 0/2 with CR[2]=1). If a set and a clear coincide, set wins.
- IRQ2 flag: set on the C2 active edge only when CR[5]=0 (CR[4] selects the edge); cleared like IRQ1. When CR[5]=1 the flag is forced to 0.
- irqx = (IRQ1 & CR[0]) | (IRQ2 & CR[3] & ~CR[5]).
- C2 output modes (CR[5]=1):
  - CR[4]=1 manual: C2 = CR[3], updated the same cycle the CR write occurs.
  - CR[4]=0, CR[3]=0 handshake:
    - A: CA2 goes low after a PA data read; returns high on the next CA1 active edge.
    - B: CB2 goes low after a PB data write; returns high on the next CB1 active edge.
  - CR[4]=0, CR[3]=1 pulse: C2 low for exactly the next clk_ena cycle after the trigger access (A: read, B: write), then high.
  - A trigger coinciding with a C1 edge leaves C2 low (trigger wins).
- Mode change mid-operation: entering an output mode drives C2 high, except in manual mode, which drives CR[3].
- DDR/OR: writes to DDR and OR are independent of each other; output pins reflect ORx at all times; oe reflects DDRx.
- reset asserted mid-handshake or mid-pulse returns all state to reset values on the next clk edge, regardless of clk_ena.
- Accesses with clk_ena=0 have no effect.

Decomposition:
- Package pia_pkg holds:
  - register address constants (PIA_DATA_A, PIA_CR_A, PIA_DATA_B, PIA_CR_B);
  - CR bit indices (CR_C1_IRQEN, CR_C1_EDGE, CR_DDR_SEL, CR_C2_CTL_LO/HI, CR_IRQ2, CR_IRQ1);
  - C2 mode enum (C2_IN, C2_HANDSHAKE, C2_PULSE, C2_MANUAL).
- Natural sub-module: pia_side, parameters PORT_W, SYNC_STAGES and IS_B. It holds one side's registers, synchroniser, flags and C2 FSM, and is instantiated twice. The top level does address decode and the data_out mux.

Test Plan:
- Reset, then read all four addrs -> 0x00 each; ca2_o=cb2_o=1; irqa=irqb=0; pa_oe=pb_oe=0.
- Setup: write CRB=0x00, DDRB=0xF0, CRB=0x04, ORB=0xA5; drive pb_i=0x3C. Response: pb_o=0xA5, pb_oe=0xF0; read addr2 -> 0xAC.
- CRA=0x07, then a cb-independent ca1 rising edge -> after SYNC_STAGES+1 clk_ena cycles CRA reads 0x87 and irqa=1. Then read addr0 -> irqa=0 and CRA reads 0x07. A falling edge sets no flag.
- CRA=0x24 (handshake) -> read addr0: ca2_o=0 from the next clk_ena cycle; ca1 falling edge (CRA[1]=0) -> ca2_o=1.
- CRB=0x2C (pulse) -> write addr2: cb2_o=0 for exactly one clk_ena cycle (4 clk), then 1. CRB=0x38 -> cb2_o=1; CRB=0x30 -> cb2_o=0.
- Simultaneous PA data read and ca1 active edge on the same clk_ena cycle -> CRA[7] stays 1 and irqa stays 1. Separately, reset asserted during a pulse -> cb2_o=1 and CRB=0 next clk.
